// File: rtl/stream_demux_n.sv
// -----------------------------------------------------------------------------
// stream_demux_n
//
// Registered 1:N valid/ready stream demultiplexer. A single producer stream is
// routed to one of N_OUT output channels selected by in_sel, or to every
// channel at once when in_bcast is set. Each channel owns a one-entry output
// register, so a word appears one cycle after acceptance and each channel can
// sustain one word per cycle (a slot may be refilled in the cycle it drains).
// Unicast requests addressed to a non-existent channel are accepted and
// discarded; such drops are counted (saturating at 255) and flagged with a
// one-cycle pulse.
//
// Parameters:
//   DATA_W  payload width in bits
//   N_OUT   number of output channels (2..16)
//   SEL_W   width of in_sel, at least clog2(N_OUT)
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    producer presents a word
//   in_ready    word is accepted this cycle (combinational)
//   in_data     producer payload
//   in_sel      destination channel index
//   in_bcast    deliver to all channels, in_sel ignored
//   out_valid   per-channel valid, bit k = channel k
//   out_ready   per-channel consumer ready
//   out_data    channel k payload at [k*DATA_W +: DATA_W]
//   drop_cnt    saturating count of words dropped for out-of-range in_sel
//   drop_pulse  high for the cycle following each drop
// -----------------------------------------------------------------------------
module stream_demux_n #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_bcast,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [7:0]              drop_cnt,
    output logic                    drop_pulse
);

    // Index compare is done one bit wider than in_sel so that N_OUT == 2**SEL_W
    // is representable and never aliases to channel 0.
    localparam logic [SEL_W:0] N_OUT_X = (SEL_W+1)'(N_OUT);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [N_OUT-1:0]  valid_q, valid_d;
    logic [DATA_W-1:0] data_q [N_OUT];
    logic [DATA_W-1:0] data_d [N_OUT];
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              drop_pulse_q, drop_pulse_d;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic [SEL_W:0]   sel_x;
    logic             sel_in_range;
    logic [N_OUT-1:0] sel_onehot;
    logic [N_OUT-1:0] slot_free;
    logic             sel_free;
    logic             accept;
    logic             drop;
    logic [N_OUT-1:0] load;

    assign sel_x        = {1'b0, in_sel};
    assign sel_in_range = (sel_x < N_OUT_X);

    always_comb begin
        sel_onehot = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            sel_onehot[k] = (sel_x == (SEL_W+1)'(k));
        end
    end

    // A slot can take a new word if it is empty or its content leaves this cycle.
    assign slot_free = ~valid_q | out_ready;

    // sel_onehot is all-zero for out-of-range indices, so no wrap-around lookup.
    assign sel_free = |(sel_onehot & slot_free);

    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &slot_free;
        end else if (sel_in_range) begin
            in_ready = sel_free;
        end
    end

    assign accept = in_valid & in_ready;
    assign drop   = accept & ~in_bcast & ~sel_in_range;

    always_comb begin
        load = '0;
        if (accept) begin
            load = in_bcast ? '1 : sel_onehot;
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        for (int unsigned k = 0; k < N_OUT; k++) begin
            data_d[k] = data_q[k];
            if (load[k]) begin
                data_d[k] = in_data;
            end
        end
        // A reload wins over a drain; an undrained word stays put.
        valid_d = load | (valid_q & ~out_ready);
    end

    always_comb begin
        drop_cnt_d   = drop_cnt_q;
        drop_pulse_d = drop;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q      <= valid_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            for (int unsigned k = 0; k < N_OUT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        out_data = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            out_data[k*DATA_W +: DATA_W] = data_q[k];
        end
    end

    assign out_valid  = valid_q;
    assign drop_cnt   = drop_cnt_q;
    assign drop_pulse = drop_pulse_q;

endmodule

// File: doc/stream_demux_n.md
Name: stream_demux_n

Overview:
- Parametrised, registered 1:N stream demultiplexer; the handshaked successor to the combinational 1:2 demux.
- Routes one valid/ready input stream to one of N_OUT output channels by index, or to all channels in broadcast mode.
- Each channel has a one-entry output register, giving 1-cycle latency and full throughput.
- Sits between a single producer and N independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- N_OUT, 4, number of output channels (2..16).
- SEL_W, 2, width of in_sel; must be >= clog2(N_OUT).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  DUT accepts this cycle (combinational).
- in_data  input  DATA_W  payload.
- in_sel  input  SEL_W  destination channel index.
- in_bcast  input  1  1 = deliver to all channels and ignore in_sel.
- out_valid  output  N_OUT  per-channel valid; bit k is channel k.
- out_ready  input  N_OUT  per-channel consumer ready.
- out_data  output  N_OUT*DATA_W  channel k payload at [k*DATA_W +: DATA_W].
- drop_cnt  output  8  count of words dropped for out-of-range in_sel.
- drop_pulse  output  1  high for one cycle after each drop.

Behaviour:
- Reset is one clock, asynchronous and active-low.
- While rst_n=0, these outputs are 0: out_valid, out_data, drop_cnt, drop_pulse.
- After reset, in_ready=1 for any legal request because all slots are empty.
- Define slot_free[k] = !out_valid[k] || out_ready[k]. A slot may be refilled in the same cycle it drains.
- in_ready is combinational:
  - in_bcast=1: in_ready = AND of slot_free over all k.
  - in_bcast=0 and in_sel < N_OUT: in_ready = slot_free[in_sel].
  - in_bcast=0 and in_sel >= N_OUT: in_ready = 1 (drop path).
- Accept = in_valid && in_ready. No other input causes a state change.
- Unicast accept (in_sel < N_OUT):
  - out_data[sel] <= in_data and out_valid[sel] <= 1 at the next edge.
  - Latency is 1 cycle.
- Broadcast accept: all N_OUT slots load in_data and set valid at the same edge, including when in_sel is out of range.
- Drop accept (in_bcast=0, in_sel >= N_OUT):
  - No slot changes.
  - drop_cnt increments by 1 and saturates at 255.
  - drop_pulse=1 for the following cycle.
- Slot drain: out_valid[k] && out_ready[k] with no reload that cycle → out_valid[k] <= 0.
  - out_data[k] holds its last value; it is not cleared.
- Drain and reload in the same cycle: out_valid[k] stays 1 and out_data[k] takes the new word. Sustained throughput is 1 word/cycle per channel.
- Unselected channels hold out_valid and out_data unchanged.
- Producer rule: while in_valid=1 and in_ready=0, the producer holds in_data, in_sel and in_bcast stable. The DUT does not check this rule.
- Consumer rule: out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- No combinational path exists from in_valid or in_data to any output, except in_ready, which depends on out_ready, in_sel and in_bcast.
- Reset asserted mid-stream immediately clears all slots. In-flight words are lost, and drop_cnt returns to 0.
- Implementation notes:
  - No latches.
  - Compare in_sel against N_OUT at SEL_W+1 bits so that no false in-range match occurs when N_OUT = 2^SEL_W.

Test Plan:
1. Reset, then in_valid=1, in_sel=2, in_data=0xA5, out_ready=4'b0000 → next cycle out_valid=4'b0100, out_data[ch2]=0xA5. in_ready for sel=2 then reads 0 and reads 1 for sel=0.
2. Streaming: 16 consecutive words 0x00..0x0F to ch1 with out_ready[1]=1 constantly → in_ready stays 1 and ch1 emits 0x00..0x0F on consecutive cycles with no bubbles.
3. Broadcast: in_bcast=1, in_data=0x3C, out_valid[3] already set with out_ready[3]=0 → in_ready=0. Raise out_ready[3] → accepted, and next cycle out_valid=4'b1111 with all channels 0x3C.
4. Drop path: N_OUT=3, SEL_W=2, in_sel=3, 300 valid words → in_ready=1 throughout, no out_valid change, drop_pulse on each, drop_cnt saturates at 255.
5. Back-pressure hold: ch0 full and stalled for 5 cycles, while ch1 receives 0x11,0x22 → ch0 out_data stable, and ch1 traffic is unaffected by ch0.
6. Async reset: assert rst_n=0 mid-cycle while 3 slots are valid → out_valid=0 and drop_cnt=0 immediately, before the next clk edge.
